// File: rtl/alu_pkg.sv
// Shared operation codes and FSM state type for the sequential ALU.
// Imported by the combinational alu and by alu_seq_unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU: AND, OR, ADD, SUB, pass-b with signed overflow.
// Any other code, MUL included, is reported as illegal with a zero result.
module alu
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alu_control,
    output logic [N-1:0] y,
    output logic         ovf,
    output logic         illegal
);

    logic [N-1:0] sum;
    logic [N-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        // NOTE: every output gets a default first so no code path leaves one unassigned and infers a latch.
        y       = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        unique case (alu_control)
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_ADD: begin
                y   = sum;
                ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                y   = diff;
                ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            ALU_PASSB: y = b;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Request/response ALU wrapper: single-cycle ops through alu, N-cycle shift-add MUL,
// registered result and flags held until the consumer accepts them.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         ovf,
    output logic         illegal
);

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [N-1:0]     result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [N-1:0]     alu_y;
    logic             alu_ovf;
    logic             alu_illegal;
    logic [2*N-1:0]   acc_nxt;

    // Fed straight from the ports: its output is captured at the acceptance edge.
    alu #(.N(N)) u_alu (
        .a           (a),
        .b           (b),
        .alu_control (ALUControl),
        .y           (alu_y),
        .ovf         (alu_ovf),
        .illegal     (alu_illegal)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        acc_nxt   = mplier_q[0] ? acc_q + mcand_q : acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (ALUControl == ALU_MUL) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{N{1'b0}}, a};
                        mplier_d = b;
                    end else begin
                        state_d   = ST_RESP;
                        result_d  = alu_y;
                        zero_d    = (alu_y == '0);
                        ovf_d     = alu_ovf;
                        illegal_d = alu_illegal;
                    end
                end
            end
            ST_MUL: begin
                // One multiplier bit per cycle; the last iteration's sum is the full product.
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    cnt_d     = '0;
                    result_d  = acc_nxt[N-1:0];
                    zero_d    = (acc_nxt[N-1:0] == '0);
                    ovf_d     = |acc_nxt[2*N-1:N];
                    illegal_d = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: latency-counting reference model checked every
// cycle, directed corner cases with literal expectations, then randomized traffic.
module tb_alu_seq_unit;
    import alu_pkg::*;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         ovf;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    alu_seq_unit #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .result     (result),
        .zero       (zero),
        .ovf        (ovf),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkn(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                     input logic [3:0] op, output logic [N-1:0] r,
                                     output logic z, output logic o, output logic il);
        logic [N:0]     s;
        logic [2*N-1:0] p;
        r  = '0;
        o  = 1'b0;
        il = 1'b0;
        case (op)
            ALU_AND:   r = x & y;
            ALU_OR:    r = x | y;
            ALU_ADD: begin
                s = {x[N-1], x} + {y[N-1], y};
                r = s[N-1:0];
                o = s[N] ^ s[N-1];
            end
            ALU_SUB: begin
                s = {x[N-1], x} - {y[N-1], y};
                r = s[N-1:0];
                o = s[N] ^ s[N-1];
            end
            ALU_PASSB: r = y;
            ALU_MUL: begin
                p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
                r = p[N-1:0];
                o = |p[2*N-1:N];
            end
            default:   il = 1'b1;
        endcase
        z = (r == '0);
    endfunction

    // Model: a transaction is busy for its latency, then presents its response until taken.
    logic         m_pending;
    logic         m_in_resp;
    int           m_left;
    logic [N-1:0] m_res;
    logic         m_z, m_o, m_il;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pending = 1'b0;
            m_in_resp = 1'b0;
            m_left    = 0;
        end else if (m_in_resp) begin
            if (rsp_ready) m_in_resp = 1'b0;
        end else if (m_pending) begin
            m_left--;
            if (m_left == 0) begin
                m_pending = 1'b0;
                m_in_resp = 1'b1;
            end
        end else if (req_valid) begin
            model_op(a, b, ALUControl, m_res, m_z, m_o, m_il);
            if (ALUControl == ALU_MUL) begin
                m_pending = 1'b1;
                m_left    = N;
            end else begin
                m_in_resp = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check1("mon_req_ready", req_ready, !(m_pending || m_in_resp));
        check1("mon_rsp_valid", rsp_valid, m_in_resp);
        if (m_in_resp) begin
            checkn("mon_result", result, m_res);
            check1("mon_zero", zero, m_z);
            check1("mon_ovf", ovf, m_o);
            check1("mon_illegal", illegal, m_il);
        end
    end

    // Called at a falling edge; returns at a falling edge with the unit idle again.
    task automatic run_op(input string nm, input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic [3:0] op, input int hold, input logic [N-1:0] er,
                          input logic ez, input logic eo, input logic eil, input int elat);
        int guard;
        int lat;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check1({nm, "_ready_before"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        a          = ia;
        b          = ib;
        ALUControl = op;
        rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        a          = {$urandom, $urandom};
        b          = {$urandom, $urandom};
        ALUControl = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_int({nm, "_latency"}, lat, elat);
        checkn({nm, "_result"}, result, er);
        check1({nm, "_zero"}, zero, ez);
        check1({nm, "_ovf"}, ovf, eo);
        check1({nm, "_illegal"}, illegal, eil);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkn({nm, "_held_result"}, result, er);
            check1({nm, "_held_req_ready"}, req_ready, 1'b0);
            check1({nm, "_held_rsp_valid"}, rsp_valid, 1'b1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check1({nm, "_idle_rsp_valid"}, rsp_valid, 1'b0);
        check1({nm, "_idle_req_ready"}, req_ready, 1'b1);
    endtask

    function automatic logic [N-1:0] rnd_operand();
        case ($urandom % 6)
            0:       return '1;
            1:       return {1'b0, {(N-1){1'b1}}};
            2:       return {1'b1, {(N-1){1'b0}}};
            3:       return N'($urandom % 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        case ($urandom % 8)
            0:       return ALU_AND;
            1:       return ALU_OR;
            2:       return ALU_ADD;
            3:       return ALU_SUB;
            4:       return ALU_PASSB;
            5:       return ALU_MUL;
            default: return 4'($urandom);
        endcase
    endfunction

    localparam logic [N-1:0] ALL1 = '1;
    localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};

    initial begin
        logic [N-1:0] pr;
        logic         pz, po, pil;

        reset      = 1'b1;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        a          = '0;
        b          = '0;
        ALUControl = '0;

        model_op(ALL1, 64'd1, ALU_ADD, pr, pz, po, pil);
        checkn("pin_add_wrap_res", pr, 64'd0);
        check1("pin_add_wrap_zero", pz, 1'b1);
        model_op(MAXP, MAXP, ALU_ADD, pr, pz, po, pil);
        checkn("pin_add_ovf_res", pr, 64'hFFFF_FFFF_FFFF_FFFE);
        check1("pin_add_ovf", po, 1'b1);
        model_op(MINN, 64'd2, ALU_MUL, pr, pz, po, pil);
        check1("pin_mul_ovf", po, 1'b1);
        check1("pin_mul_zero", pz, 1'b1);

        #1;
        check1("rst_req_ready", req_ready, 1'b1);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        checkn("rst_result", result, '0);
        check1("rst_zero", zero, 1'b0);
        check1("rst_ovf", ovf, 1'b0);
        check1("rst_illegal", illegal, 1'b0);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("add_wrap",  ALL1, 64'd1, ALU_ADD, 0, 64'd0, 1'b1, 1'b0, 1'b0, 1);
        run_op("add_ovf",   MAXP, MAXP, ALU_ADD, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1);
        run_op("mul_small", 64'd100, 64'd200, ALU_MUL, 0, 64'd20000, 1'b0, 1'b0, 1'b0, 65);
        run_op("mul_ovf",   MINN, 64'd2, ALU_MUL, 0, 64'd0, 1'b1, 1'b1, 1'b0, 65);
        run_op("mul_max",   ALL1, ALL1, ALU_MUL, 0, 64'd1, 1'b0, 1'b1, 1'b0, 65);
        run_op("sub_bp",    64'd200, 64'd100, ALU_SUB, 5, 64'd100, 1'b0, 1'b0, 1'b0, 1);
        run_op("sub_ovf",   MINN, 64'd1, ALU_SUB, 0, MAXP, 1'b0, 1'b1, 1'b0, 1);
        run_op("illegal",   64'd55, 64'd66, 4'b1111, 0, 64'd0, 1'b1, 1'b0, 1'b1, 1);
        run_op("and",       64'hF0F0, 64'hFF00, ALU_AND, 0, 64'hF000, 1'b0, 1'b0, 1'b0, 1);
        run_op("or",        64'hF0F0, 64'h0F00, ALU_OR, 0, 64'hFFF0, 1'b0, 1'b0, 1'b0, 1);
        run_op("passb",     ALL1, 64'h1234, ALU_PASSB, 0, 64'h1234, 1'b0, 1'b0, 1'b0, 1);

        // Abort a multiply 30 cycles in.
        req_valid  = 1'b1;
        a          = 64'd3;
        b          = 64'd5;
        ALUControl = ALU_MUL;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (29) @(negedge clk);
        check1("mid_mul_busy", req_ready, 1'b0);
        #2 reset = 1'b1;
        #1;
        check1("abort_rsp_valid", rsp_valid, 1'b0);
        check1("abort_req_ready", req_ready, 1'b1);
        checkn("abort_result", result, '0);
        check1("abort_zero", zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_abort", 64'd5, 64'd7, ALU_ADD, 0, 64'd12, 1'b0, 1'b0, 1'b0, 1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_valid  = ($urandom % 3) != 0;
            a          = rnd_operand();
            b          = rnd_operand();
            ALUControl = rnd_op();
            rsp_ready  = ($urandom % 4) != 0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (N + 5) @(negedge clk);
        check1("drain_idle", req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
